// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD unit.
// State encoding, algorithm selectors and a width helper.
package gcd_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_t;

   localparam int GCD_SUB = 0;
   localparam int GCD_BIN = 1;

   // Ceiling log2, used to size the shared power-of-two counter k
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gcd_step.sv
// One reduction step of the GCD iteration.
// Purely combinational; MODE picks subtractive or binary.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MODE  = GCD_SUB,
   parameter int KW    = clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH-1:0] x_o,
   output logic [WIDTH-1:0] y_o,
   output logic [KW-1:0]    k_o,
   output logic             finish_o,
   output logic [WIDTH-1:0] res_o,
   output logic             err_o
);

   logic xz, yz, xev, yev, bin;

   assign xz  = (x_i == '0);
   assign yz  = (y_i == '0);
   assign xev = ~x_i[0];
   assign yev = ~y_i[0];
   assign bin = (MODE == GCD_BIN);

   // First matching rule wins: finish checks, then binary halving, then subtract
   always_comb begin
      x_o      = x_i;
      y_o      = y_i;
      k_o      = k_i;
      finish_o = 1'b0;
      res_o    = '0;
      err_o    = 1'b0;
      if (xz || yz) begin
         finish_o = 1'b1;
         res_o    = (x_i | y_i) << k_i;
         err_o    = xz && yz;
      end else if (x_i == y_i) begin
         finish_o = 1'b1;
         res_o    = x_i << k_i;
      end else if (bin && xev && yev) begin
         x_o = x_i >> 1;
         y_o = y_i >> 1;
         k_o = k_i + KW'(1);
      end else if (bin && xev) begin
         x_o = x_i >> 1;
      end else if (bin && yev) begin
         y_o = y_i >> 1;
      end else if (x_i > y_i) begin
         x_o = x_i - y_i;
      end else begin
         y_o = y_i - x_i;
      end
   end

endmodule

// File: rtl/gcd_unit.sv
// Self-sequencing GCD engine with start/done handshake.
// Registers, FSM and outputs; the step logic is in gcd_step.
module gcd_unit
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MODE  = GCD_SUB
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] xin,
   input  logic [WIDTH-1:0] yin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] gcd_out,
   output logic             err
);

   localparam int KW = clog2(WIDTH + 1);

   state_t           state_q;
   logic [WIDTH-1:0] x_q, y_q;
   logic [KW-1:0]    k_q;
   logic             busy_q, done_q, err_q;
   logic [WIDTH-1:0] gcd_q;

   logic [WIDTH-1:0] x_d, y_d, res_d;
   logic [KW-1:0]    k_d;
   logic             fin_d, err_d;

   gcd_step #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .KW    (KW)
   ) u_step (
      .x_i      (x_q),
      .y_i      (y_q),
      .k_i      (k_q),
      .x_o      (x_d),
      .y_o      (y_d),
      .k_o      (k_d),
      .finish_o (fin_d),
      .res_o    (res_d),
      .err_o    (err_d)
   );

   // FSM: load operands on start, iterate, publish result with a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gcd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  x_q     <= xin;
                  y_q     <= yin;
                  k_q     <= '0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (fin_d) begin
                  gcd_q   <= res_d;
                  err_q   <= err_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  x_q <= x_d;
                  y_q <= y_d;
                  k_q <= k_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign gcd_out = gcd_q;
   assign err     = err_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: one subtractive and one binary instance.
// Expected results are queued at start and checked on done.
module tb_gcd_unit;

   localparam int LIMIT = 600;

   typedef struct {
      logic [7:0] g;
      logic       e;
      int         edges;
      int         t0;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       st [2];
   logic [7:0] xi [2];
   logic [7:0] yi [2];
   logic       bz [2];
   logic       dn [2];
   logic [7:0] go [2];
   logic       er [2];

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t sb0[$];
   exp_t sb1[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   gcd_unit #(.WIDTH(8), .MODE(0)) u_sub (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (st[0]),
      .xin     (xi[0]),
      .yin     (yi[0]),
      .busy    (bz[0]),
      .done    (dn[0]),
      .gcd_out (go[0]),
      .err     (er[0])
   );

   gcd_unit #(.WIDTH(8), .MODE(1)) u_bin (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (st[1]),
      .xin     (xi[1]),
      .yin     (yi[1]),
      .busy    (bz[1]),
      .done    (dn[1]),
      .gcd_out (go[1]),
      .err     (er[1])
   );

   function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic issue(input int d, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] g, input logic e, input int edges,
                        input string tag, input bit sync);
      exp_t t;
      if (sync) @(negedge clk);
      xi[d] = x;
      yi[d] = y;
      st[d] = 1'b1;
      t.g = g;
      t.e = e;
      t.edges = edges;
      t.t0 = cyc + 1;
      t.tag = tag;
      if (d == 0) sb0.push_back(t);
      else sb1.push_back(t);
      @(negedge clk);
      st[d] = 1'b0;
   endtask

   task automatic wait_check(input int d);
      exp_t t;
      int   n;
      bit   bok;
      n = 0;
      bok = 1'b1;
      while (dn[d] !== 1'b1 && n < LIMIT) begin
         if (bz[d] !== 1'b1) bok = 1'b0;
         @(negedge clk);
         n++;
      end
      if (d == 0) t = sb0.pop_front();
      else t = sb1.pop_front();
      chk({t.tag, ":timeout"}, 32'(n < LIMIT), 1);
      chk({t.tag, ":gcd"}, go[d], t.g);
      chk({t.tag, ":err"}, er[d], t.e);
      chk({t.tag, ":busy_drop"}, bz[d], 0);
      chk({t.tag, ":busy_hold"}, bok, 1);
      if (t.edges >= 0) chk({t.tag, ":edges"}, cyc - t.t0 + 1, t.edges);
   endtask

   initial begin
      logic [7:0] rx, ry;
      bit anydone;
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         st[d] = 1'b0;
         xi[d] = '0;
         yi[d] = '0;
      end
      #1 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst:busy", bz[d], 0);
         chk("rst:done", dn[d], 0);
         chk("rst:gcd", go[d], 0);
         chk("rst:err", er[d], 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(0, 12, 18, 6, 0, 4, "sub12_18", 1);
      wait_check(0);
      issue(1, 12, 18, 6, 0, 6, "bin12_18", 1);
      wait_check(1);

      for (int d = 0; d < 2; d++) begin
         issue(d, 0, 9, 9, 0, 2, "zero9", 1);
         wait_check(d);
         issue(d, 0, 0, 0, 1, 2, "zero0", 1);
         wait_check(d);
         @(negedge clk);
         chk("err_hold", er[d], 1);
         chk("done_pulse", dn[d], 0);
         issue(d, 5, 5, 5, 0, 2, "eq5", 1);
         chk("err_clear", er[d], 0);
         wait_check(d);
      end

      issue(0, 255, 1, 1, 0, 256, "long", 1);
      repeat (3) @(negedge clk);
      xi[0] = 7;
      yi[0] = 3;
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      wait_check(0);
      issue(0, 7, 3, 1, 0, 6, "b2b", 0);
      chk("b2b:busy", bz[0], 1);
      chk("b2b:done", dn[0], 0);
      wait_check(0);

      @(negedge clk);
      xi[0] = 255;
      yi[0] = 1;
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort:busy", bz[0], 0);
      chk("abort:done", dn[0], 0);
      chk("abort:gcd", go[0], 0);
      chk("abort:err", er[0], 0);
      chk("abort:gcd_bin", go[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      anydone = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (dn[0] === 1'b1 || bz[0] === 1'b1) anydone = 1'b1;
      end
      chk("abort:quiet", anydone, 0);

      issue(0, 21, 14, 7, 0, 4, "sub21_14", 1);
      wait_check(0);
      issue(1, 21, 14, 7, 0, 5, "bin21_14", 1);
      wait_check(1);

      for (int i = 0; i < 6; i++) begin
         rx = 8'($urandom_range(0, 255));
         ry = 8'($urandom_range(0, 255));
         for (int d = 0; d < 2; d++) begin
            issue(d, rx, ry, ref_gcd(rx, ry), (rx == 0 && ry == 0), -1, "rand", 1);
            wait_check(d);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
